// File: rtl/dut_pkg.sv
// Shared types and default sizing for the multiply engine and its private data memory.
package dut_pkg;

    localparam int NUM_PAIRS_DEF = 16;
    localparam int SRC_BASE_DEF  = 0;
    localparam int DST_BASE_DEF  = 64;
    localparam int MEM_DEPTH_DEF = 256;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        STORE = 3'd3,
        NEXT  = 3'd4,
        FIN   = 3'd5
    } state_t;

    // Byte k of a product, k = 0 selects the most significant byte.
    function automatic byte_t prod_byte(input logic [31:0] p, input logic [1:0] k);
        byte_t b;
        case (k)
            2'd0:    b = p[31:24];
            2'd1:    b = p[23:16];
            2'd2:    b = p[15:8];
            default: b = p[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: one synchronous write port, combinational read.
// Contents are deliberately not reset so data preloaded during reset survives.
module data_mem
    import dut_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    byte_t core [0:DEPTH-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            core[waddr] <= wdata;
        end
    end

    assign rdata = core[raddr];

endmodule

// File: rtl/dut.sv
// Unsigned 16x16 multiply engine: reads operand pairs from dm, writes 32-bit products back.
// Build option DUT_SINGLE_CYCLE_MULT_EN replaces the 16-cycle shift-add with a one-cycle multiply.
module dut #(
    parameter int NUM_PAIRS = dut_pkg::NUM_PAIRS_DEF,
    parameter int SRC_BASE  = dut_pkg::SRC_BASE_DEF,
    parameter int DST_BASE  = dut_pkg::DST_BASE_DEF,
    parameter int MEM_DEPTH = dut_pkg::MEM_DEPTH_DEF
) (
    input  logic Clk,
    input  logic Reset,
    output logic Done
);
    import dut_pkg::*;

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    state_t          state_r;
    state_t          state_s;
    logic [PW-1:0]   pair_r;
    logic [3:0]      cnt_r;
    logic [31:0]     mcand_r;
    word_t           mplier_r;
    logic [31:0]     acc_r;
    logic            done_r;

    logic            we_s;
    logic [AW-1:0]   pair_off_s;
    logic [AW-1:0]   raddr_s;
    logic [AW-1:0]   waddr_s;
    byte_t           rdata_s;
    byte_t           wdata_s;

    data_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) dm (
        .clk   (Clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Each pair owns four consecutive bytes on both the source and destination side.
    always_comb begin
        pair_off_s = AW'({pair_r, 2'b00});
        raddr_s    = AW'(SRC_BASE) + pair_off_s + AW'(cnt_r[1:0]);
        waddr_s    = AW'(DST_BASE) + pair_off_s + AW'(cnt_r[1:0]);
        we_s       = (state_r == STORE);
        wdata_s    = prod_byte(acc_r, cnt_r[1:0]);
    end

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: state_s = LOAD;
            LOAD: begin
                if (cnt_r == 4'd3) state_s = MUL;
                else               state_s = LOAD;
            end
            MUL: begin
`ifdef DUT_SINGLE_CYCLE_MULT_EN
                state_s = STORE;
`else
                if (cnt_r == 4'd15) state_s = STORE;
                else                state_s = MUL;
`endif
            end
            STORE: begin
                if (cnt_r == 4'd3) state_s = NEXT;
                else               state_s = STORE;
            end
            NEXT: begin
                if (pair_r == PW'(NUM_PAIRS - 1)) state_s = FIN;
                else                              state_s = LOAD;
            end
            FIN:     state_s = FIN;
            default: state_s = IDLE;
        endcase
    end

    // Datapath: phase counter, operand capture, multiply, pair index and Done flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_r    <= 4'd0;
            pair_r   <= '0;
            mcand_r  <= 32'd0;
            mplier_r <= 16'd0;
            acc_r    <= 32'd0;
            done_r   <= 1'b0;
        end else begin
            if ((state_s == state_r) && (state_r != FIN)) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= 4'd0;
            end

            done_r <= (state_r == FIN);

            case (state_r)
                IDLE: begin
                    pair_r <= '0;
                end
                LOAD: begin
                    acc_r <= 32'd0;
                    case (cnt_r[1:0])
                        2'd0:    mcand_r        <= {16'd0, rdata_s, 8'd0};
                        2'd1:    mcand_r[7:0]   <= rdata_s;
                        2'd2:    mplier_r[15:8] <= rdata_s;
                        default: mplier_r[7:0]  <= rdata_s;
                    endcase
                end
                MUL: begin
`ifdef DUT_SINGLE_CYCLE_MULT_EN
                    acc_r <= 32'(mcand_r[15:0]) * 32'(mplier_r);
`else
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r  <= {mcand_r[30:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[15:1]};
`endif
                end
                NEXT: begin
                    if (pair_r != PW'(NUM_PAIRS - 1)) begin
                        pair_r <= pair_r + PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Done = done_r;

endmodule

// File: tb/tb_dut.sv
// Scoreboard bench for dut: preloads dm.core, queues expected products, checks them after Done.
module tb_dut;

`ifdef DUT_SINGLE_CYCLE_MULT_EN
    localparam int EXP_LAT = 162;
`else
    localparam int EXP_LAT = 402;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic Done;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [15:0] ops [32];
    logic [7:0]  snap [256];

    dut u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called with Reset low: operands in, garbage over the product area, expectations queued.
    task automatic preload();
        for (int i = 0; i < 32; i++) begin
            u_dut.dm.core[2*i]   = ops[i][15:8];
            u_dut.dm.core[2*i+1] = ops[i][7:0];
        end
        for (int i = 64; i < 128; i++) begin
            u_dut.dm.core[i] = 8'($urandom);
        end
        exp_q.delete();
        for (int j = 0; j < 16; j++) begin
            exp_q.push_back(32'(ops[2*j+1]) * 32'(ops[2*j]));
        end
        for (int i = 0; i < 256; i++) begin
            snap[i] = u_dut.dm.core[i];
        end
    endtask

    task automatic release_and_wait(output int cyc);
        @(negedge Clk);
        Reset = 1'b1;
        cyc = 0;
        while (cyc < 1000) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (Done === 1'b1) break;
        end
    endtask

    task automatic verify(input string tag);
        logic [31:0] word;
        logic [31:0] exp;
        int diffs;
        for (int j = 0; j < 16; j++) begin
            word = {u_dut.dm.core[64+4*j], u_dut.dm.core[64+4*j+1],
                    u_dut.dm.core[64+4*j+2], u_dut.dm.core[64+4*j+3]};
            exp = exp_q.pop_front();
            check($sformatf("%s_p%0d", tag, j), word, exp);
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) begin
            if ((i < 64 || i >= 128) && (u_dut.dm.core[i] !== snap[i])) diffs++;
        end
        check({tag, "_keep"}, 32'(diffs), 32'd0);
    endtask

    task automatic run(input string tag);
        int cyc;
        preload();
        release_and_wait(cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(EXP_LAT));
        verify(tag);
        #2;
        Reset = 1'b0;
        #1;
        check({tag, "_rstdone"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        logic [31:0] w0;
        #3;
        check("reset_done", {31'd0, Done}, 32'd0);
        repeat (2) @(posedge Clk);

        for (int i = 0; i < 32; i++) ops[i] = 16'h0000;
        run("zero");

        for (int i = 0; i < 32; i++) ops[i] = 16'hFFFF;
        run("ffff");

        for (int i = 0; i < 32; i++) ops[i] = 16'h0000;
        ops[0] = 16'h1234;
        ops[1] = 16'd1;
        run("unit");

        for (int i = 0; i < 32; i++) ops[i] = 16'h0000;
        ops[0] = 16'd500;
        ops[1] = 16'd300;
        ops[2] = 16'd2;
        ops[3] = 16'h8000;
        run("mix");

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 32; i++) ops[i] = 16'($urandom);
            run($sformatf("rnd%0d", r));
        end

        // Reset in the middle of a run, then a full rerun over fresh garbage.
        for (int i = 0; i < 32; i++) ops[i] = 16'($urandom);
        preload();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (100) @(posedge Clk);
        #1;
        check("mid_done_low", {31'd0, Done}, 32'd0);
        Reset = 1'b0;
        #1;
        check("mid_rst_done", {31'd0, Done}, 32'd0);
        w0 = {u_dut.dm.core[64], u_dut.dm.core[65], u_dut.dm.core[66], u_dut.dm.core[67]};
        check("mid_p0_kept", w0, exp_q[0]);
        repeat (3) @(posedge Clk);
        run("rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dut.md
Name: dut

Overview:
- Self-contained double-precision unsigned multiply engine with private byte-wide data memory.
- After reset release, reads 16 pairs of 16-bit operands from memory bytes 0..63.
- Writes 16 32-bit products to bytes 64..127, then raises Done.
- Top-level program-3 block; the bench loads and inspects memory hierarchically via instance dm, array core.

Parameters:
NUM_PAIRS, 16, number of operand pairs / products
SRC_BASE, 0, byte address of first operand
DST_BASE, 64, byte address of first product
MEM_DEPTH, 256, data memory size in bytes

Ports:
Clk  input  1  single clock, rising-edge
Reset  input  1  asynchronous, active-low reset (asserted when 0)
Done  output  1  high when all products written

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Memory:
  - Sub-module instance named dm, storage array named core, MEM_DEPTH x 8 bits.
  - One synchronous write port; combinational read.
  - Reset never clears core, so contents preloaded while in reset survive.
- Operand layout, big-endian: operand i = {core[SRC_BASE+2i], core[SRC_BASE+2i+1]}, i = 0..31.
- Products: P[j] = op[2j+1] * op[2j], unsigned, full 32 bits, no truncation.
- Product storage: core[DST_BASE+4j .. +3] = P[j][31:24], [23:16], [15:8], [7:0].
- Bytes outside the 64 product bytes and the operand region are never written.
- FSM states: IDLE, LOAD, MUL, STORE, NEXT, FIN.
  - Reset asserted: state=IDLE, pair index=0, Done=0, accumulators cleared.
  - IDLE -> LOAD on first Clk edge after release.
  - LOAD: 4 cycles, one byte per cycle into multiplicand A (op[2j]) and multiplier B (op[2j+1]).
  - MUL: 16-cycle shift-add. Test LSB of B, conditionally add A shifted into a 32-bit accumulator, shift.
  - STORE: 4 cycles, one byte per cycle, MSB first.
  - NEXT: if j == NUM_PAIRS-1 go to FIN, else j++ and return to LOAD.
  - FIN: Done=1 (registered), no further memory writes. Held until Reset asserts.
- Latency: 25 cycles per pair; Done rises 1 + 16*25 + 1 = 402 cycles after release (default build).
- Done never pulses before FIN.
- Reset mid-operation: immediate return to IDLE, Done=0.
  - Already-written product bytes remain.
  - Next run restarts from pair 0 and overwrites all products.
- Operands equal to zero or 0xFFFF need no special handling.
- Max product 0xFFFE0001 must not overflow.

Optional Feature:
- Macro DUT_SINGLE_CYCLE_MULT_EN.
- Defined: MUL state is 1 cycle using a combinational 16x16 multiply; latency 10 cycles/pair, Done at cycle 162.
- Undefined: 16-cycle shift-add as above.
- Memory results identical in both builds.

Decomposition:
- Package dut_pkg:
  - state enum type
  - NUM_PAIRS, SRC_BASE, DST_BASE, MEM_DEPTH defaults
  - byte_t (8-bit) and word_t (16-bit) typedefs
- One sub-module data_mem, instantiated as dm, with array core.
- FSM and datapath live in dut.

Test Plan:
- All operands 0 -> all 64 product bytes 0; Done high after release.
- All operands 0xFFFF -> every product 0xFFFE0001 (bytes FF FE 00 01).
- op[1]=1, op[0]=0x1234 -> P[0]=0x00001234 at bytes 64..67 = 00 00 12 34.
- op[1]=300, op[0]=500; op[3]=0x8000, op[2]=2 -> P[0]=150000, P[1]=0x00010000.
- Random 10 operand sets, reset pulsed between runs -> all 16 products match per run; Done low during reset, high only after final STORE.
- Assert Reset at cycle 100, release, rerun -> Done deasserts immediately, final memory fully correct; bytes 0..63 and 128..255 unchanged.
